fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage for TinyCPU, directly upstream of the instruction decoder. It owns the program counter and issues one-word reads to a synchronous instruction memory with fixed one-cycle read latency. Returned words go into a 2-entry buffer that presents a valid/ready stream of 32-bit instructions, each tagged with its PC, to the decode stage. A redirect input from the jump path flushes in-flight and buffered instructions and restarts fetch at a new target.

## Interface
- RESET_PC, 32'h0000_0000: PC of the first fetch after reset.
- PC_INC, 32'd1: PC increment per fetched word. Memory is word-addressed.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-low. State clears on a rising clk edge while rst=0.
- imem_req  output  1  read request this cycle.
- imem_addr  output  32  read address; equals fetch_pc.
- imem_rdata  input  32  read data; valid in the cycle after a cycle with imem_req=1.
- redirect_valid  input  1  jump taken; flush and restart.
- redirect_target  input  32  new fetch PC, sampled when redirect_valid=1.
- instr_valid  output  1  instr/instr_pc hold a valid instruction.
- instr_ready  input  1  decode accepts the instruction this cycle.
- instr  output  32  instruction word; bits [31:27] are the instruction type field used by decode.
- instr_pc  output  32  PC the word was fetched from.

## Operation
- State:
  - fetch_pc (32 bits).
  - inflight (1 bit): a request was issued last cycle.
  - 2-entry FIFO of {pc, word}, with read pointer, write pointer and 2-bit count.
  - inflight_pc (32 bits).
- Pop: a pop occurs when instr_valid && instr_ready.
- Issue rule: imem_req = rst && !redirect_valid && (count + inflight − pop) < 2. This credit rule guarantees that a returning word never finds the buffer full.
- When a request issues:
  - fetch_pc <= fetch_pc + PC_INC, modulo 2^32 (0xFFFF_FFFF wraps to 0).
  - inflight <= 1 and inflight_pc <= fetch_pc.
  - Otherwise inflight <= 0.
- Capture: if inflight=1 and redirect_valid=0, write {inflight_pc, imem_rdata} to the FIFO tail. If inflight=0, imem_rdata is ignored.
- Outputs: instr_valid = (count != 0). instr and instr_pc show the FIFO head. They are registered, with no combinational path from imem_rdata.
- Simultaneous capture and pop: count is unchanged, both pointers advance.
- Redirect (redirect_valid=1):
  - FIFO cleared (count, pointers to 0).
  - Any response arriving in this cycle is discarded.
  - No request issues this cycle, and inflight <= 0.
  - fetch_pc <= redirect_target.
  - A pop in the same cycle is a completed handshake: that instruction counts as delivered to decode.
- Redirect on consecutive cycles: the last target wins, and each cycle flushes again.
- instr_valid, once asserted, stays asserted with instr and instr_pc stable until popped or a redirect occurs.
- Reset (rst=0, any cycle including mid-fetch):
  - fetch_pc <= RESET_PC; inflight <= 0; FIFO cleared.
  - A response arriving in the first cycle after reset is dropped because inflight=0.

## Timing
- Reset values, in the cycle after a reset edge: instr_valid=0, instr=0, instr_pc=0, imem_addr=RESET_PC.
- imem_req is 0 whenever rst=0. In the first cycle with rst=1 it is 1, because count and inflight are 0.
- Fetch latency: request in cycle N, data on imem_rdata in N+1, instr_valid in N+2.
- Redirect latency: redirect in cycle R, request to redirect_target in R+1, instr_valid in R+3.
- Throughput: one instruction per cycle in steady state with instr_ready held at 1.
- Backpressure: with instr_ready=0, at most 2 words are buffered and in flight combined. Requests stop and resume in the cycle the first pop occurs.
- The buffer never overflows; no word is dropped except by redirect or reset.

## Test plan
- Reset release, RESET_PC=0x10, memory returns mem[a]=a*3, instr_ready=1: instr_valid rises 2 cycles after the first imem_req; instr/instr_pc sequence is (0x30,0x10), (0x33,0x11), … with one instruction per cycle and no gaps.
- Backpressure: hold instr_ready=0 for 5 cycles from steady state: exactly 2 entries are held, imem_req=0 for ≥3 cycles, instr stays stable; on release, PCs continue contiguously with no duplicate or missing PC.
- Redirect with a full buffer and a request in flight, target 0x200: buffered words never appear; the next instr_valid shows instr_pc=0x200 exactly 3 cycles after the redirect cycle.
- Redirect and pop in the same cycle: the popped instruction is counted once; the following instruction has instr_pc=target.
- PC wrap: redirect to 0xFFFF_FFFF: instr_pc sequence is 0xFFFF_FFFF then 0x0000_0000.
- Reset asserted for 1 cycle while inflight=1 and count=2: the next cycle shows instr_valid=0 and imem_addr=RESET_PC; the stale response is not captured; the first instruction delivered has instr_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch stage bus bundle: instruction memory port, redirect input and the
// instruction stream to decode. Master is the fetch side, slave the environment.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_rdata, redirect_valid, redirect_target, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_rdata, redirect_valid, redirect_target, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency imem and
// buffers words in a 2-entry FIFO feeding decode. Ports: clk, rst (sync, low), bus.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd1
) (
    input logic    clk,
    input logic    rst,
    fetch_if.master bus
);
    logic [31:0]      fetch_pc;
    logic [31:0]      inflight_pc;
    logic             inflight;
    logic [1:0][31:0] buf_pc;
    logic [1:0][31:0] buf_word;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             pop;
    logic             capture;
    logic [2:0]       credit;

    assign pop = bus.instr_valid && bus.instr_ready;

    // Buffered plus in-flight words after this cycle's pop; keeping this
    // below 2 means a returning word always has a free slot.
    assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    assign bus.imem_req = rst && !bus.redirect_valid && (credit < 3'd2);
    assign capture      = inflight && !bus.redirect_valid;

    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = (count != 2'd0);
    assign bus.instr       = buf_word[rd_ptr];
    assign bus.instr_pc    = buf_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            buf_pc      <= '0;
            buf_word    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_target;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (bus.imem_req) begin
                fetch_pc    <= fetch_pc + PC_INC;
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
            end else begin
                inflight <= 1'b0;
            end

            if (capture) begin
                buf_pc[wr_ptr]   <= inflight_pc;
                buf_word[wr_ptr] <= bus.imem_rdata;
                wr_ptr           <= ~wr_ptr;
            end

            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            unique case (1'b1)
                capture && !pop: count <= count + 2'd1;
                pop && !capture: count <= count - 2'd1;
                default:         count <= count;
            endcase
        end
    end
endmodule
